fibo_stream_checker: RTL and testbench

Receive-side counterpart of the Fibonacci sequence generator. It consumes the generator's 8-bit output stream, one value per accepted beat. It seeds itself from the first two values and from then on predicts every next value as the sum of the previous two, mod 2^W. It reports per-beat match pulses, a sticky mismatch flag and a saturating match counter, and sits between the generator's output and the regression scoreboard or status registers.

---
 rtl/fibo_stream_checker.sv | 105 ++++++++++
 tb/tb_fibo_stream_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fibo_stream_checker.sv
// Receive-side checker for a Fibonacci stream: seeds from two beats, then predicts
// each next value as the W-bit sum of the previous two and flags the first mismatch.
module fibo_stream_checker #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [W-1:0]  din,
    output logic          locked,
    output logic          ok,
    output logic          err,
    output logic [W-1:0]  expected,
    output logic [CW-1:0] match_count
);

    typedef enum logic [1:0] {StSeed0, StSeed1, StTrack, StFault} stateT;

    stateT         stateQ, stateD;
    logic [W-1:0]  aQ, aD, bQ, bD;
    logic [W-1:0]  expQ, expD;
    logic [W-1:0]  predict;
    logic [CW-1:0] countQ, countD;
    logic          okQ, okD;
    logic          errQ, errD;
    logic          lockedQ, lockedD;

    assign predict = aQ + bQ;

    always_comb begin
        stateD = stateQ;
        aD     = aQ;
        bD     = bQ;
        countD = countQ;
        okD    = 1'b0;
        errD   = errQ;
        if (clear) begin
            // clear wins over a coincident beat; that beat is dropped
            stateD = StSeed0;
            aD     = '0;
            bD     = '0;
            countD = '0;
            errD   = 1'b0;
        end else if (in_valid) begin
            unique case (stateQ)
                StSeed0: begin
                    aD     = din;
                    stateD = StSeed1;
                end
                StSeed1: begin
                    bD     = din;
                    stateD = StTrack;
                end
                StTrack: begin
                    if (din == predict) begin
                        aD  = bQ;
                        bD  = din;
                        okD = 1'b1;
                        if (countQ != {CW{1'b1}}) begin
                            countD = countQ + 1'b1;
                        end
                    end else begin
                        errD   = 1'b1;
                        stateD = StFault;
                    end
                end
                StFault: begin
                end
            endcase
        end
        expD    = aD + bD;
        lockedD = (stateD == StTrack);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= StSeed0;
            aQ      <= '0;
            bQ      <= '0;
            expQ    <= '0;
            countQ  <= '0;
            okQ     <= 1'b0;
            errQ    <= 1'b0;
            lockedQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            aQ      <= aD;
            bQ      <= bD;
            expQ    <= expD;
            countQ  <= countD;
            okQ     <= okD;
            errQ    <= errD;
            lockedQ <= lockedD;
        end
    end

    assign locked      = lockedQ;
    assign ok          = okQ;
    assign err         = errQ;
    assign expected    = expQ;
    assign match_count = countQ;

endmodule

// File: tb/tb_fibo_stream_checker.sv
// Directed bench for fibo_stream_checker; a second instance with CW=4 covers saturation.
module tb_fibo_stream_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  din = '0;
    logic        locked, ok, err;
    logic [7:0]  expected;
    logic [15:0] match_count;
    logic        lockedS, okS, errS;
    logic [7:0]  expectedS;
    logic [3:0]  matchCountS;

    int errors = 0;
    int checks = 0;
    int okPulses = 0;
    int okPulsesS = 0;
    logic [7:0] p, q, nxt;

    always #5 clk = ~clk;

    fibo_stream_checker #(.W(8), .CW(16)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .din(din),
        .locked(locked), .ok(ok), .err(err), .expected(expected), .match_count(match_count)
    );

    fibo_stream_checker #(.W(8), .CW(4)) dutSat (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .din(din),
        .locked(lockedS), .ok(okS), .err(errS), .expected(expectedS),
        .match_count(matchCountS)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat, then sample 1 ns after the accepting edge.
    task automatic beat(input logic [7:0] v, input logic withClear);
        @(negedge clk);
        in_valid = 1'b1;
        din      = v;
        clear    = withClear;
        @(posedge clk);
        #1;
        if (ok) okPulses++;
        if (okS) okPulsesS++;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic doClear();
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        okPulses  = 0;
        okPulsesS = 0;
    endtask

    initial begin
        // reset
        #2 rst = 1'b1;
        #1;
        check("rst_locked", locked, 0);
        check("rst_ok", ok, 0);
        check("rst_err", err, 0);
        check("rst_expected", expected, 0);
        check("rst_count", match_count, 0);
        @(negedge clk);
        rst = 1'b0;

        // nominal
        beat(8'd0, 1'b0);
        check("nom_unlocked_after_seed0", locked, 0);
        beat(8'd1, 1'b0);
        check("nom_locked_after_seed1", locked, 1);
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b0);
        beat(8'd3, 1'b0);
        beat(8'd5, 1'b0);
        beat(8'd8, 1'b0);
        beat(8'd13, 1'b0);
        check("nom_ok_pulses", okPulses, 6);
        check("nom_count", match_count, 6);
        check("nom_err", err, 0);
        check("nom_expected", expected, 21);
        idle();
        check("nom_ok_idle", ok, 0);

        // wrap-around
        doClear();
        check("clr_locked", locked, 0);
        check("clr_count", match_count, 0);
        beat(8'd89, 1'b0);
        beat(8'd144, 1'b0);
        beat(8'd233, 1'b0);
        beat(8'd121, 1'b0);
        check("wrap_ok_pulses", okPulses, 2);
        check("wrap_err", err, 0);
        check("wrap_expected", expected, 98);

        // mismatch and re-arm
        doClear();
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b0);
        beat(8'd3, 1'b0);
        check("mm_ok_on_3", ok, 1);
        beat(8'd6, 1'b0);
        check("mm_err", err, 1);
        check("mm_locked", locked, 0);
        check("mm_ok_on_6", ok, 0);
        beat(8'd9, 1'b0);
        check("mm_fault_ok", ok, 0);
        check("mm_fault_count", match_count, 1);
        check("mm_fault_err", err, 1);
        doClear();
        check("mm_clear_err", err, 0);
        check("mm_clear_locked", locked, 0);
        beat(8'd5, 1'b0);
        beat(8'd5, 1'b0);
        beat(8'd10, 1'b0);
        check("mm_rearm_err", err, 0);
        check("mm_rearm_count", match_count, 1);
        check("mm_rearm_locked", locked, 1);

        // gaps and clear together with a beat
        doClear();
        beat(8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin idle(); check("gap_ok_idle_a", ok, 0); end
        beat(8'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin idle(); check("gap_ok_idle_b", ok, 0); end
        beat(8'd1, 1'b0);
        check("gap_ok_on_1", ok, 1);
        for (int i = 0; i < 3; i++) begin idle(); check("gap_ok_idle_c", ok, 0); end
        beat(8'd2, 1'b1);
        check("gap_clr_locked", locked, 0);
        check("gap_clr_count", match_count, 0);
        check("gap_clr_ok", ok, 0);
        beat(8'd7, 1'b0);
        check("gap_seed0_unlocked", locked, 0);
        beat(8'd7, 1'b0);
        beat(8'd14, 1'b0);
        check("gap_reseed_locked", locked, 1);
        check("gap_reseed_count", match_count, 1);

        // saturation on the CW=4 instance
        doClear();
        beat(8'd0, 1'b0);
        beat(8'd1, 1'b0);
        p = 8'd0;
        q = 8'd1;
        for (int i = 0; i < 20; i++) begin
            nxt = p + q;
            p   = q;
            q   = nxt;
            beat(nxt, 1'b0);
            if (i == 14) check("sat_count_at_15", matchCountS, 15);
        end
        check("sat_count_held", matchCountS, 15);
        check("sat_ok_pulses", okPulsesS, 20);
        check("sat_wide_count", match_count, 20);
        beat(p + q + 8'd1, 1'b0);
        check("sat_err_set", errS, 1);
        check("sat_err_count_held", matchCountS, 15);

        // asynchronous reset in the middle of tracking
        doClear();
        beat(8'd1, 1'b0);
        beat(8'd1, 1'b0);
        beat(8'd2, 1'b0);
        beat(8'd3, 1'b0);
        beat(8'd5, 1'b0);
        beat(8'd8, 1'b0);
        check("rmid_count_before", match_count, 4);
        #2;
        in_valid = 1'b0;
        clear    = 1'b0;
        rst      = 1'b1;
        #1;
        check("rmid_locked", locked, 0);
        check("rmid_ok", ok, 0);
        check("rmid_err", err, 0);
        check("rmid_expected", expected, 0);
        check("rmid_count", match_count, 0);
        @(negedge clk);
        rst = 1'b0;
        beat(8'd7, 1'b0);
        beat(8'd7, 1'b0);
        beat(8'd14, 1'b0);
        check("rmid_after_locked", locked, 1);
        check("rmid_after_count", match_count, 1);
        check("rmid_after_ok", ok, 1);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
